// File: rtl/bcd_scan_driver_pkg.sv
// Shared constants and types for the multiplexed 4-digit 7-segment scan driver.
package bcd_scan_driver_pkg;

    typedef logic [1:0] digit_idx_t;

    // Segment order {dp, g, f, e, d, c, b, a}, active-high.
    localparam logic [7:0] SEG_0    = 8'h3F;
    localparam logic [7:0] SEG_1    = 8'h06;
    localparam logic [7:0] SEG_2    = 8'h5B;
    localparam logic [7:0] SEG_3    = 8'h4F;
    localparam logic [7:0] SEG_4    = 8'h66;
    localparam logic [7:0] SEG_5    = 8'h6D;
    localparam logic [7:0] SEG_6    = 8'h7D;
    localparam logic [7:0] SEG_7    = 8'h07;
    localparam logic [7:0] SEG_8    = 8'h7F;
    localparam logic [7:0] SEG_9    = 8'h6F;
    localparam logic [7:0] SEG_DASH = 8'h40;
    localparam logic [7:0] SEG_OFF  = 8'h00;

    localparam logic [3:0] AN_OFF   = 4'b1111;

    // Active-low one-cold anode enable for a digit slot.
    function automatic logic [3:0] an_select(input digit_idx_t idx);
        an_select = ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/bcd_seg_decode.sv
// Combinational BCD digit + decimal point to 7-segment pattern; non-BCD codes show a dash.
module bcd_seg_decode
    import bcd_scan_driver_pkg::*;
(
    input  logic [3:0] bcd,
    input  logic       dp,
    output logic [7:0] seg_c
);

    logic [7:0] glyph;

    always_comb begin
        glyph = SEG_DASH;
        case (bcd)
            4'd0:    glyph = SEG_0;
            4'd1:    glyph = SEG_1;
            4'd2:    glyph = SEG_2;
            4'd3:    glyph = SEG_3;
            4'd4:    glyph = SEG_4;
            4'd5:    glyph = SEG_5;
            4'd6:    glyph = SEG_6;
            4'd7:    glyph = SEG_7;
            4'd8:    glyph = SEG_8;
            4'd9:    glyph = SEG_9;
            default: glyph = SEG_DASH;
        endcase
        seg_c = {glyph[7] | dp, glyph[6:0]};
    end

endmodule

// File: rtl/bcd_scan_driver.sv
// Four-digit multiplexed 7-segment driver: frame-synchronous display register,
// rotating active-low anodes, optional leading-zero blanking.
module bcd_scan_driver
    import bcd_scan_driver_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] digits_in,
    input  logic [3:0]  dp_in,
    input  logic        blank_lz,
    output logic [7:0]  seg,
    output logic [3:0]  an,
    output logic        frame_done
);

    localparam int unsigned CW = $clog2(SCAN_DIV);

    logic [CW-1:0] cnt_q, cnt_d;
    digit_idx_t    ptr_q, ptr_d;
    logic [15:0]   pend_digits_q, pend_digits_d;
    logic [3:0]    pend_dp_q, pend_dp_d;
    logic          pend_valid_q, pend_valid_d;
    logic [15:0]   disp_digits_q, disp_digits_d;
    logic [3:0]    disp_dp_q, disp_dp_d;
    logic [7:0]    seg_q, seg_d;
    logic [3:0]    an_q, an_d;
    logic          frame_done_q, frame_done_d;

    logic          tick;
    logic          wrap;
    logic [3:0]    cur_digit;
    logic          cur_dp;
    logic [3:0]    lz;
    logic          blank_slot;
    logic [7:0]    dec_seg_c;

    // Prescaler, digit pointer, and the pending -> display handoff at frame boundaries.
    always_comb begin
        tick          = (cnt_q == CW'(SCAN_DIV - 1));
        wrap          = tick && (ptr_q == 2'd3);
        cnt_d         = tick ? '0 : cnt_q + CW'(1);
        ptr_d         = tick ? ptr_q + 2'd1 : ptr_q;
        pend_digits_d = pend_digits_q;
        pend_dp_d     = pend_dp_q;
        pend_valid_d  = pend_valid_q;
        disp_digits_d = disp_digits_q;
        disp_dp_d     = disp_dp_q;
        if (wrap) begin
            pend_valid_d = 1'b0;
            if (load) begin
                disp_digits_d = digits_in;
                disp_dp_d     = dp_in;
            end else if (pend_valid_q) begin
                disp_digits_d = pend_digits_q;
                disp_dp_d     = pend_dp_q;
            end
        end else if (load) begin
            pend_digits_d = digits_in;
            pend_dp_d     = dp_in;
            pend_valid_d  = 1'b1;
        end
    end

    // Slot content is taken from the post-update display so a wrap-cycle load shows at once.
    always_comb begin
        case (ptr_d)
            2'd0:    cur_digit = disp_digits_d[3:0];
            2'd1:    cur_digit = disp_digits_d[7:4];
            2'd2:    cur_digit = disp_digits_d[11:8];
            default: cur_digit = disp_digits_d[15:12];
        endcase
        cur_dp = disp_dp_d[ptr_d];

        lz[3]      = (disp_digits_d[15:12] == 4'd0);
        lz[2]      = lz[3] && (disp_digits_d[11:8] == 4'd0);
        lz[1]      = lz[2] && (disp_digits_d[7:4] == 4'd0);
        lz[0]      = 1'b0;
        blank_slot = blank_lz && lz[ptr_d];

        seg_d        = seg_q;
        an_d         = an_q;
        frame_done_d = wrap;
        if (tick) begin
            seg_d = blank_slot ? SEG_OFF : dec_seg_c;
            an_d  = blank_slot ? AN_OFF : an_select(ptr_d);
        end
    end

    bcd_seg_decode u_dec (
        .bcd   (cur_digit),
        .dp    (cur_dp),
        .seg_c (dec_seg_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q         <= '0;
            ptr_q         <= 2'd3;
            pend_digits_q <= '0;
            pend_dp_q     <= '0;
            pend_valid_q  <= 1'b0;
            disp_digits_q <= '0;
            disp_dp_q     <= '0;
            seg_q         <= SEG_OFF;
            an_q          <= AN_OFF;
            frame_done_q  <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            ptr_q         <= ptr_d;
            pend_digits_q <= pend_digits_d;
            pend_dp_q     <= pend_dp_d;
            pend_valid_q  <= pend_valid_d;
            disp_digits_q <= disp_digits_d;
            disp_dp_q     <= disp_dp_d;
            seg_q         <= seg_d;
            an_q          <= an_d;
            frame_done_q  <= frame_done_d;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_bcd_scan_driver.sv
// Directed bench for bcd_scan_driver with SCAN_DIV=4 (16-cycle frames).
module tb_bcd_scan_driver;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load;
    logic [15:0] digits_in;
    logic [3:0]  dp_in;
    logic        blank_lz;
    logic [7:0]  seg;
    logic [3:0]  an;
    logic        frame_done;

    int errors = 0;
    int checks = 0;

    bcd_scan_driver #(.SCAN_DIV(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .digits_in  (digits_in),
        .dp_in      (dp_in),
        .blank_lz   (blank_lz),
        .seg        (seg),
        .an         (an),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Advance to the negedge where frame_done is high (slot 0 just updated).
    task automatic wait_frame(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_done && n < 40);
        checks++;
        if (frame_done !== 1'b1) begin
            errors++;
            $display("FAIL %s frame_wait: frame_done=%b after %0d cycles, want 1", tag, frame_done, n);
        end
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] p);
        load      = 1'b1;
        digits_in = d;
        dp_in     = p;
        @(negedge clk);
        load      = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; load = 1'b0; digits_in = '0; dp_in = '0; blank_lz = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (seg !== 8'h00 || an !== 4'b1111 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: seg=%h an=%b fd=%b want 00 1111 0", seg, an, frame_done);
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (an !== 4'b1111 || seg !== 8'h00) begin
            errors++;
            $display("FAIL reset_pre_tick: seg=%h an=%b want 00 1111", seg, an);
        end
        @(negedge clk);
        checks++;
        if (frame_done !== 1'b1 || an !== 4'b1110 || seg !== 8'h3F) begin
            errors++;
            $display("FAIL reset_first_tick: fd=%b an=%b seg=%h want 1 1110 3f", frame_done, an, seg);
        end
    endtask

    task automatic test_idle_scan();
        logic [3:0] exp_an [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        wait_frame("idle");
        @(negedge clk);
        checks++;
        if (frame_done !== 1'b0) begin
            errors++;
            $display("FAIL idle_fd_width: fd=%b want 0", frame_done);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (an !== 4'b1110) begin
            errors++;
            $display("FAIL idle_slot_hold: an=%b want 1110", an);
        end
        for (int d = 1; d < 4; d++) begin
            repeat (4) @(negedge clk);
            checks++;
            if (an !== exp_an[d] || seg !== 8'h3F) begin
                errors++;
                $display("FAIL idle_d%0d: an=%b seg=%h want %b 3f", d, an, seg, exp_an[d]);
            end
        end
        repeat (1) @(negedge clk);
        checks++;
        if (frame_done !== 1'b1 || an !== 4'b1110) begin
            errors++;
            $display("FAIL idle_frame_period: fd=%b an=%b want 1 1110", frame_done, an);
        end
    endtask

    task automatic test_midframe_load();
        logic [7:0] exp_seg [4] = '{8'h66, 8'hCF, 8'h5B, 8'h06};
        logic [3:0] exp_an  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        wait_frame("midload_a");
        do_load(16'h1234, 4'b0010);
        for (int d = 1; d < 4; d++) begin
            repeat (4) @(negedge clk);
            checks++;
            if (an !== exp_an[d] || seg !== 8'h3F) begin
                errors++;
                $display("FAIL midload_old_d%0d: an=%b seg=%h want %b 3f", d, an, seg, exp_an[d]);
            end
        end
        wait_frame("midload_b");
        for (int d = 0; d < 4; d++) begin
            checks++;
            if (an !== exp_an[d] || seg !== exp_seg[d]) begin
                errors++;
                $display("FAIL midload_new_d%0d: an=%b seg=%h want %b %h", d, an, seg, exp_an[d], exp_seg[d]);
            end
            if (d < 3) repeat (4) @(negedge clk);
        end
    endtask

    task automatic test_blanking();
        logic [7:0] exp_seg [4] = '{8'h3F, 8'h6D, 8'h00, 8'h00};
        logic [3:0] exp_an  [4] = '{4'b1110, 4'b1101, 4'b1111, 4'b1111};
        logic [7:0] nob_seg [4] = '{8'h3F, 8'h6D, 8'h3F, 8'h3F};
        logic [3:0] nob_an  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        blank_lz = 1'b1;
        do_load(16'h0050, 4'b1100);
        wait_frame("blank_on");
        for (int d = 0; d < 4; d++) begin
            checks++;
            if (an !== exp_an[d] || seg !== exp_seg[d]) begin
                errors++;
                $display("FAIL blank_on_d%0d: an=%b seg=%h want %b %h", d, an, seg, exp_an[d], exp_seg[d]);
            end
            if (d < 3) repeat (4) @(negedge clk);
        end
        blank_lz = 1'b0;
        do_load(16'h0050, 4'b0000);
        wait_frame("blank_off");
        for (int d = 0; d < 4; d++) begin
            checks++;
            if (an !== nob_an[d] || seg !== nob_seg[d]) begin
                errors++;
                $display("FAIL blank_off_d%0d: an=%b seg=%h want %b %h", d, an, seg, nob_an[d], nob_seg[d]);
            end
            if (d < 3) repeat (4) @(negedge clk);
        end
    endtask

    task automatic test_dash();
        logic [7:0] exp_seg [4] = '{8'h40, 8'h40, 8'h00, 8'h00};
        logic [3:0] exp_an  [4] = '{4'b1110, 4'b1101, 4'b1111, 4'b1111};
        blank_lz = 1'b1;
        do_load(16'h00AF, 4'b0000);
        wait_frame("dash");
        for (int d = 0; d < 4; d++) begin
            checks++;
            if (an !== exp_an[d] || seg !== exp_seg[d]) begin
                errors++;
                $display("FAIL dash_d%0d: an=%b seg=%h want %b %h", d, an, seg, exp_an[d], exp_seg[d]);
            end
            if (d < 3) repeat (4) @(negedge clk);
        end
        blank_lz = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_an [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        wait_frame("b2b_a");
        do_load(16'h1111, 4'b0000);
        @(negedge clk);
        do_load(16'h2222, 4'b0000);
        wait_frame("b2b_b");
        for (int d = 0; d < 4; d++) begin
            checks++;
            if (an !== exp_an[d] || seg !== 8'h5B) begin
                errors++;
                $display("FAIL b2b_d%0d: an=%b seg=%h want %b 5b", d, an, seg, exp_an[d]);
            end
            if (d < 3) repeat (4) @(negedge clk);
        end
    endtask

    task automatic test_wrap_load();
        logic [7:0] exp_seg [4] = '{8'h7F, 8'h07, 8'h7D, 8'hED};
        logic [3:0] exp_an  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        wait_frame("wrap_a");
        repeat (15) @(negedge clk);
        do_load(16'h5678, 4'b1000);
        checks++;
        if (frame_done !== 1'b1) begin
            errors++;
            $display("FAIL wrap_fd: fd=%b want 1", frame_done);
        end
        for (int d = 0; d < 4; d++) begin
            checks++;
            if (an !== exp_an[d] || seg !== exp_seg[d]) begin
                errors++;
                $display("FAIL wrap_d%0d: an=%b seg=%h want %b %h", d, an, seg, exp_an[d], exp_seg[d]);
            end
            if (d < 3) repeat (4) @(negedge clk);
        end
    endtask

    task automatic test_async_reset();
        logic [3:0] exp_an [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        repeat (2) @(negedge clk);
        do_load(16'h9999, 4'b1111);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (seg !== 8'h00 || an !== 4'b1111 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: seg=%h an=%b fd=%b want 00 1111 0", seg, an, frame_done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        wait_frame("arst_a");
        for (int d = 0; d < 4; d++) begin
            checks++;
            if (an !== exp_an[d] || seg !== 8'h3F) begin
                errors++;
                $display("FAIL arst_d%0d: an=%b seg=%h want %b 3f", d, an, seg, exp_an[d]);
            end
            if (d < 3) repeat (4) @(negedge clk);
        end
        wait_frame("arst_b");
        checks++;
        if (an !== 4'b1110 || seg !== 8'h3F) begin
            errors++;
            $display("FAIL arst_pending_lost: an=%b seg=%h want 1110 3f", an, seg);
        end
    endtask

    initial begin
        test_reset();
        test_idle_scan();
        test_midframe_load();
        test_blanking();
        test_dash();
        test_back_to_back();
        test_wrap_load();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
